// File: rtl/altair_panel_pkg.sv
// rtl/altair_panel_pkg.sv - scan codes, panel command and FSM state types for altair_panel_ctrl
package altair_panel_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Control-row column index of each momentary switch
    typedef enum logic [2:0] {
        CMD_STOP      = 3'd0,
        CMD_RUN       = 3'd1,
        CMD_STEP      = 3'd2,
        CMD_EXAM      = 3'd3,
        CMD_EXAM_NEXT = 3'd4,
        CMD_DEP       = 3'd5,
        CMD_DEP_NEXT  = 3'd6,
        CMD_RESET     = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT_WAIT = 3'd1,
        ST_RD        = 3'd2,
        ST_WR        = 3'd3,
        ST_PULSE     = 3'd4
    } state_e;

endpackage

// File: rtl/altair_panel_ctrl_ps2_event_detect.sv
// rtl/altair_panel_ctrl_ps2_event_detect.sv - turns the hps_io toggle bit into press/release pulses
module ps2_event_detect (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_toggle,
    input  logic        key_pressed,
    input  logic [7:0]  key_scan,
    output logic        key_press,
    output logic        key_release,
    output logic [7:0]  key_code
);

    logic toggle_q;
    logic key_event;

    assign key_event = key_toggle ^ toggle_q;

    // Register the toggle bit and emit a one-cycle press or release pulse with its code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_code    <= 8'h00;
        end else begin
            toggle_q    <= key_toggle;
            key_press   <= key_event & key_pressed;
            key_release <= key_event & ~key_pressed;
            key_code    <= key_scan;
        end
    end

endmodule

// File: rtl/altair_panel_ctrl.sv
// rtl/altair_panel_ctrl.sv - Altair 8800 front-panel key decoder, switch state and command sequencer
module altair_panel_ctrl
    import altair_panel_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        cpu_halted,
    output logic        cpu_halt_req,
    output logic        cpu_step,
    output logic        cpu_reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] addr_sw,
    output logic [15:0] addr_led,
    output logic [7:0]  data_led,
    output logic [3:0]  cursor_x,
    output logic        cursor_y,
    output logic        cursor_action,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    logic       key_press;
    logic       key_release;
    logic [7:0] key_code;
    logic       unused_ext;

    // Extended-code flag is deliberately not decoded
    assign unused_ext = ps2_key[8];

    ps2_event_detect u_event (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_toggle  (ps2_key[10]),
        .key_pressed (ps2_key[9]),
        .key_scan    (ps2_key[7:0]),
        .key_press   (key_press),
        .key_release (key_release),
        .key_code    (key_code)
    );

    logic space_press;
    logic cmd_valid;
    cmd_e cmd;

    assign space_press = key_press && (key_code == SC_SPACE);
    assign cmd_valid   = space_press && cursor_y && !cursor_x[3];
    assign cmd         = cmd_e'(cursor_x[2:0]);

    // Cursor movement, SPACE hold flag and toggle-switch flips (allowed in any FSM state)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursor_x      <= 4'd0;
            cursor_y      <= 1'b0;
            cursor_action <= 1'b0;
            addr_sw       <= 16'h0000;
        end else if (key_press) begin
            case (key_code)
                SC_A:     cursor_x <= cursor_x - 4'd1;
                SC_D:     cursor_x <= cursor_x + 4'd1;
                SC_W:     cursor_y <= 1'b1;
                SC_S:     cursor_y <= 1'b0;
                SC_SPACE: begin
                    cursor_action <= 1'b1;
                    // Column 0 is the leftmost switch, i.e. bit 15
                    if (!cursor_y)
                        addr_sw[~cursor_x] <= ~addr_sw[~cursor_x];
                end
                default: ;
            endcase
        end else if (key_release && (key_code == SC_SPACE)) begin
            cursor_action <= 1'b0;
        end
    end

    state_e      state, state_n;
    logic [15:0] to_cnt, to_cnt_n;
    logic        halt_req_n, step_n, creset_n, req_n, we_n, to_err_n;
    logic [15:0] addr_n, led_addr_n, addr_inc;
    logic [7:0]  wdata_n, led_data_n;

    assign addr_inc = addr_led + 16'd1;
    assign busy     = (state != ST_IDLE);

    // FSM and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            to_cnt       <= 16'd0;
            cpu_halt_req <= 1'b0;
            cpu_step     <= 1'b0;
            cpu_reset    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 8'h00;
            addr_led     <= 16'h0000;
            data_led     <= 8'h00;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            to_cnt       <= to_cnt_n;
            cpu_halt_req <= halt_req_n;
            cpu_step     <= step_n;
            cpu_reset    <= creset_n;
            mem_req      <= req_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            addr_led     <= led_addr_n;
            data_led     <= led_data_n;
            timeout_err  <= to_err_n;
        end
    end

    // Next-state and next-output decode; memory commands need a halted CPU
    always_comb begin
        state_n    = state;
        to_cnt_n   = to_cnt;
        halt_req_n = cpu_halt_req;
        step_n     = 1'b0;
        creset_n   = 1'b0;
        req_n      = mem_req;
        we_n       = mem_we;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        led_addr_n = addr_led;
        led_data_n = data_led;
        to_err_n   = timeout_err;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    to_err_n = 1'b0;
                    to_cnt_n = 16'd0;
                    case (cmd)
                        CMD_STOP: begin
                            halt_req_n = 1'b1;
                            state_n    = ST_HALT_WAIT;
                        end
                        CMD_RUN: halt_req_n = 1'b0;
                        CMD_STEP: begin
                            if (cpu_halted) begin
                                step_n  = 1'b1;
                                state_n = ST_PULSE;
                            end
                        end
                        CMD_RESET: begin
                            creset_n = 1'b1;
                            state_n  = ST_PULSE;
                        end
                        CMD_EXAM, CMD_EXAM_NEXT: begin
                            if (cpu_halted) begin
                                led_addr_n = (cmd == CMD_EXAM) ? addr_sw : addr_inc;
                                addr_n     = led_addr_n;
                                req_n      = 1'b1;
                                we_n       = 1'b0;
                                state_n    = ST_RD;
                            end
                        end
                        CMD_DEP, CMD_DEP_NEXT: begin
                            if (cpu_halted) begin
                                led_addr_n = (cmd == CMD_DEP) ? addr_led : addr_inc;
                                addr_n     = led_addr_n;
                                wdata_n    = addr_sw[7:0];
                                req_n      = 1'b1;
                                we_n       = 1'b1;
                                state_n    = ST_WR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT_WAIT: begin
                if (cpu_halted)
                    state_n = ST_IDLE;
            end
            ST_RD, ST_WR: begin
                // Ack is checked first so an ack on the timeout cycle still succeeds
                if (mem_ack) begin
                    req_n      = 1'b0;
                    led_data_n = (state == ST_RD) ? mem_rdata : mem_wdata;
                    state_n    = ST_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    req_n    = 1'b0;
                    to_err_n = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
            end
            ST_PULSE: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_altair_panel_ctrl.sv
// tb/tb_altair_panel_ctrl.sv - directed self-checking bench for altair_panel_ctrl
module tb_altair_panel_ctrl;

    localparam int TO = 20;
    localparam logic [7:0] K_A = 8'h1C, K_D = 8'h23, K_W = 8'h1D, K_S = 8'h1B, K_SP = 8'h29;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        cpu_halted;
    logic        cpu_halt_req, cpu_step, cpu_reset;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, addr_sw, addr_led;
    logic [7:0]  mem_wdata, mem_rdata, data_led;
    logic [3:0]  cursor_x;
    logic        cursor_y, cursor_action, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0]  cx;
    logic [15:0] pat;

    altair_panel_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_key       (ps2_key),
        .cpu_halted    (cpu_halted),
        .cpu_halt_req  (cpu_halt_req),
        .cpu_step      (cpu_step),
        .cpu_reset     (cpu_reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .addr_sw       (addr_sw),
        .addr_led      (addr_led),
        .data_led      (data_led),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .cursor_action (cursor_action),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one key event; returns at the falling edge after the DUT has acted on it
    task automatic key(input logic [7:0] code, input logic pressed);
        @(negedge clk);
        ps2_key[10]  = ~ps2_key[10];
        ps2_key[9]   = pressed;
        ps2_key[7:0] = code;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tap(input logic [7:0] code);
        key(code, 1'b1);
        key(code, 1'b0);
    endtask

    task automatic move_to(input logic [3:0] tx);
        while (cx != tx) begin
            tap(K_D);
            cx = cx + 4'd1;
        end
    endtask

    task automatic ack(input logic [7:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        ps2_key    = 11'd0;
        cpu_halted = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 8'h00;
        cx         = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_addr_sw", addr_sw, 0);
        check("rst_halt_req", cpu_halt_req, 0);
        reset_n = 1'b1;

        // Cursor movement and wrap
        repeat (3) tap(K_D);
        tap(K_W);
        check("cursor_x_3", cursor_x, 3);
        check("cursor_y_1", cursor_y, 1);
        repeat (4) tap(K_A);
        check("cursor_x_wrap", cursor_x, 15);
        cx = 4'd15;

        // Row 0 toggle of the leftmost switch
        move_to(4'd0);
        tap(K_S);
        key(K_SP, 1'b1);
        check("sw_8000", addr_sw, 16'h8000);
        check("action_hi", cursor_action, 1);
        key(K_SP, 1'b0);
        check("action_lo", cursor_action, 0);
        key(K_SP, 1'b1);
        check("sw_0000", addr_sw, 16'h0000);
        key(K_SP, 1'b0);

        // EXAM while running is ignored
        tap(K_W);
        move_to(4'd3);
        key(K_SP, 1'b1);
        check("exam_run_req", mem_req, 0);
        check("exam_run_led", addr_led, 0);
        check("exam_run_busy", busy, 0);
        key(K_SP, 1'b0);

        // STOP waits for the CPU to halt
        move_to(4'd0);
        key(K_SP, 1'b1);
        check("stop_halt_req", cpu_halt_req, 1);
        check("stop_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("stop_busy_wait", busy, 1);
        cpu_halted = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stop_busy_done", busy, 0);
        key(K_SP, 1'b0);

        // Set switches to 0x12AB
        tap(K_S);
        pat = 16'h12AB;
        for (int x = 0; x < 16; x++) begin
            move_to(4'(x));
            if (pat[15 - x]) tap(K_SP);
        end
        check("sw_12ab", addr_sw, 16'h12AB);

        // EXAM read
        tap(K_W);
        move_to(4'd3);
        key(K_SP, 1'b1);
        check("exam_req", mem_req, 1);
        check("exam_we", mem_we, 0);
        check("exam_addr", mem_addr, 16'h12AB);
        check("exam_led", addr_led, 16'h12AB);
        ack(8'h3E);
        check("exam_data", data_led, 8'h3E);
        check("exam_req_off", mem_req, 0);
        check("exam_busy_off", busy, 0);
        key(K_SP, 1'b0);

        // DEP_NEXT write
        move_to(4'd6);
        key(K_SP, 1'b1);
        check("depn_req", mem_req, 1);
        check("depn_we", mem_we, 1);
        check("depn_addr", mem_addr, 16'h12AC);
        check("depn_wdata", mem_wdata, 8'hAB);
        ack(8'h00);
        check("depn_data", data_led, 8'hAB);
        check("depn_led", addr_led, 16'h12AC);
        check("depn_busy", busy, 0);
        key(K_SP, 1'b0);

        // STEP is a one-cycle pulse
        move_to(4'd2);
        key(K_SP, 1'b1);
        check("step_hi", cpu_step, 1);
        check("step_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("step_lo", cpu_step, 0);
        check("step_idle", busy, 0);
        key(K_SP, 1'b0);

        // Switches to 0xFFFF
        tap(K_S);
        for (int x = 0; x < 16; x++) begin
            move_to(4'(x));
            if (!pat[15 - x]) tap(K_SP);
        end
        check("sw_ffff", addr_sw, 16'hFFFF);
        tap(K_W);
        move_to(4'd3);
        key(K_SP, 1'b1);
        check("exam_ffff_addr", mem_addr, 16'hFFFF);
        ack(8'h55);
        check("exam_ffff_data", data_led, 8'h55);
        key(K_SP, 1'b0);

        // EXAM_NEXT wraps, then times out
        move_to(4'd4);
        key(K_SP, 1'b1);
        check("examn_addr", mem_addr, 16'h0000);
        check("examn_led", addr_led, 16'h0000);
        check("examn_req", mem_req, 1);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("to_busy_pre", busy, 1);
        check("to_err_pre", timeout_err, 0);
        @(posedge clk);
        @(negedge clk);
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_req", mem_req, 0);
        key(K_SP, 1'b0);

        // DEP clears the error; reset during the write
        move_to(4'd5);
        key(K_SP, 1'b1);
        check("dep_to_clr", timeout_err, 0);
        check("dep_req", mem_req, 1);
        check("dep_we", mem_we, 1);
        check("dep_wdata", mem_wdata, 8'hFF);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_halt", cpu_halt_req, 0);
        check("arst_sw", addr_sw, 0);
        check("arst_led", {addr_led, data_led}, 0);
        check("arst_cursor", {cursor_x, cursor_y, cursor_action}, 0);
        check("arst_busy_to", {busy, timeout_err, cpu_step, cpu_reset}, 0);
        check("arst_mem", {mem_addr, mem_wdata}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
